// File: rtl/matrix_tx_sched_if.sv
// Word-transmitter handshake between the matrix transmit scheduler and the UART word transmitter.
interface matrix_tx_sched_if #(
  parameter int unsigned W = 32
);
  logic [W-1:0] tx_data;
  logic         tx_start;
  logic         tx_busy;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_busy
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_busy
  );
endinterface

// File: rtl/matrix_tx_sched.sv
// Transmit-side controller for the UART matrix link: owns a 2x4 cell matrix, decodes the action
// bus and feeds cell/row/column word sequences to the word transmitter, with one queued command.
module matrix_tx_sched #(
  parameter int unsigned W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      d,
  input  logic              row,
  input  logic [1:0]        col,
  input  logic [3:0]        action,
  matrix_tx_sched_if.master tx,
  output logic              t_busy,
  output logic              t_pending,
  output logic              t_drop,
  output logic [W-1:0]      t_cell
);

  typedef enum logic [1:0] {StIdle, StLoad, StAck, StDone} state_e;
  typedef enum logic [1:0] {KindCell, KindRow, KindCol} kind_e;

  logic [W-1:0] cell_q [2][4];
  logic [3:0]   action_q;

  state_e       state_q, state_d;
  kind_e        act_kind_q, act_kind_d;
  logic         act_row_q, act_row_d;
  logic [1:0]   act_col_q, act_col_d;
  logic [1:0]   idx_q, idx_d;

  logic         pend_valid_q, pend_valid_d;
  kind_e        pend_kind_q, pend_kind_d;
  logic         pend_row_q, pend_row_d;
  logic [1:0]   pend_col_q, pend_col_d;

  logic [W-1:0] tx_data_q;
  logic         tx_start_q;
  logic         t_busy_q;
  logic         t_drop_q;
  logic [W-1:0] t_cell_q;

  logic         fire;
  kind_e        fire_kind;
  logic         last_word;
  logic         sel_row;
  logic [1:0]   sel_col;
  logic         load_pend;
  logic         load_fire;
  logic         pend_free;
  logic         drop;

  // Decode the edge-triggered transmit command and which word of the active list is current.
  always_comb begin
    fire      = (action inside {4'd2, 4'd3, 4'd4}) && (action != action_q);
    fire_kind = KindCell;
    sel_row   = act_row_q;
    sel_col   = act_col_q;
    last_word = 1'b1;
    case (action)
      4'd3:    fire_kind = KindRow;
      4'd4:    fire_kind = KindCol;
      default: fire_kind = KindCell;
    endcase
    case (act_kind_q)
      KindRow: begin
        sel_col   = idx_q;
        last_word = (idx_q == 2'd3);
      end
      KindCol: begin
        sel_row   = idx_q[0];
        last_word = (idx_q == 2'd1);
      end
      default: begin
        last_word = 1'b1;
      end
    endcase
  end

  // Next-state logic for the sequencer, active command and single-entry pending slot.
  always_comb begin
    state_d      = state_q;
    act_kind_d   = act_kind_q;
    act_row_d    = act_row_q;
    act_col_d    = act_col_q;
    idx_d        = idx_q;
    pend_valid_d = pend_valid_q;
    pend_kind_d  = pend_kind_q;
    pend_row_d   = pend_row_q;
    pend_col_d   = pend_col_q;
    load_pend    = 1'b0;
    load_fire    = 1'b0;
    pend_free    = 1'b0;
    drop         = 1'b0;

    case (state_q)
      StIdle: begin
        if (pend_valid_q) begin
          load_pend = 1'b1;
          pend_free = 1'b1;
          state_d   = StLoad;
        end else if (fire) begin
          load_fire = 1'b1;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        state_d = StAck;
      end
      StAck: begin
        if (tx.tx_busy) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!tx.tx_busy) begin
          if (!last_word) begin
            idx_d   = idx_q + 2'd1;
            state_d = StLoad;
          end else if (pend_valid_q) begin
            load_pend = 1'b1;
            pend_free = 1'b1;
            state_d   = StLoad;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (load_pend) begin
      act_kind_d = pend_kind_q;
      act_row_d  = pend_row_q;
      act_col_d  = pend_col_q;
      idx_d      = 2'd0;
    end
    if (load_fire) begin
      act_kind_d = fire_kind;
      act_row_d  = row;
      act_col_d  = col;
      idx_d      = 2'd0;
    end

    if (pend_free) begin
      pend_valid_d = 1'b0;
    end
    // A slot freed on this same edge can take the new command; the decision uses pre-edge state.
    if (fire && !load_fire) begin
      if (!pend_valid_q || pend_free) begin
        pend_valid_d = 1'b1;
        pend_kind_d  = fire_kind;
        pend_row_d   = row;
        pend_col_d   = col;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // Sequencer, command and pending registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      action_q     <= 4'd0;
      act_kind_q   <= KindCell;
      act_row_q    <= 1'b0;
      act_col_q    <= 2'd0;
      idx_q        <= 2'd0;
      pend_valid_q <= 1'b0;
      pend_kind_q  <= KindCell;
      pend_row_q   <= 1'b0;
      pend_col_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      action_q     <= action;
      act_kind_q   <= act_kind_d;
      act_row_q    <= act_row_d;
      act_col_q    <= act_col_d;
      idx_q        <= idx_d;
      pend_valid_q <= pend_valid_d;
      pend_kind_q  <= pend_kind_d;
      pend_row_q   <= pend_row_d;
      pend_col_q   <= pend_col_d;
    end
  end

  // Cell matrix; level-sensitive writes, allowed at any time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 4; c++) begin
          cell_q[r][c] <= '0;
        end
      end
    end else if (action == 4'd1) begin
      cell_q[row][col] <= d;
    end
  end

  // Registered outputs: word and start strobe from LOAD, status flags and cell readback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      t_busy_q   <= 1'b0;
      t_drop_q   <= 1'b0;
      t_cell_q   <= '0;
    end else begin
      if (state_q == StLoad) begin
        tx_data_q <= cell_q[sel_row][sel_col];
      end
      tx_start_q <= (state_q == StLoad);
      t_busy_q   <= (state_d != StIdle);
      t_drop_q   <= drop;
      t_cell_q   <= cell_q[row][col];
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_start = tx_start_q;
  assign t_busy      = t_busy_q;
  assign t_pending   = pend_valid_q;
  assign t_drop      = t_drop_q;
  assign t_cell      = t_cell_q;

endmodule
